// File: rtl/ila_uart_defs_pkg.sv
// Shared UART definitions for the ILA command path.
// UART_RX_PARITY_EN: when defined, receivers expect an even parity bit between
// the last data bit and the stop bit (8E1); otherwise frames are plain 8N1.
package ila_uart_defs;

    // 10 MHz system clock, 115200 baud
    localparam int unsigned DefaultClksPerBit = 87;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StDone,
        StWaitIdle
    } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous single-bit inputs. Resets to 1 so an
// idle-high line reads idle straight out of reset.
module sync_2ff (
    input  logic i_clk,
    input  logic i_reset,
    input  logic d,
    output logic q
);

    logic meta_q;

    // Two-stage capture with synchronous active-low reset to 1.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            meta_q <= 1'b1;
            q      <= 1'b1;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/uart_byte_receiver.sv
// UART byte receiver: oversamples the host line, deframes LSB-first characters
// and strobes each good byte for one cycle. Malformed characters only pulse an
// error flag. Define UART_RX_PARITY_EN to expect an even parity bit (8E1).
module uart_byte_receiver
    import ila_uart_defs::*;
#(
    parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_rx,
    output logic [7:0] o_Byte,
    output logic       o_ready_read,
    output logic       o_frame_err,
    output logic       o_parity_err,
    output logic       o_busy
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntBit  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);

    logic            rx_s;
    rx_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      byte_q, byte_d;
    logic            frame_err_q, frame_err_d;
    logic            parity_err_q, parity_err_d;
    logic            parity_fail;

    sync_2ff u_sync_rx (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .d       (i_rx),
        .q       (rx_s)
    );

`ifdef UART_RX_PARITY_EN
    logic parity_bad_q, parity_bad_d;

    // Holds the parity verdict until the stop bit decides which error wins.
    always_ff @(posedge i_clk) begin
        if (!i_reset) parity_bad_q <= 1'b0;
        else          parity_bad_q <= parity_bad_d;
    end

    assign parity_fail = parity_bad_q;
`else
    assign parity_fail = 1'b0;
`endif

    // State, counters, data and output flag registers.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            byte_q       <= '0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            byte_q       <= byte_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
        end
    end

    // Deframing FSM; error pulses are resolved at the stop-bit sample so a
    // frame error always takes priority over a parity error.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shift_d      = shift_q;
        byte_d       = byte_q;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bad_d = parity_bad_q;
`endif
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rx_s) state_d = StStart;
            end
            StStart: begin
                if (cnt_q == CntHalf) begin
                    cnt_d   = '0;
                    // A high line at mid-start is a glitch: drop silently.
                    state_d = rx_s ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (cnt_q == CntBit) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (cnt_q == CntBit) begin
                    cnt_d        = '0;
                    parity_bad_d = (rx_s != ^shift_q);
                    state_d      = StStop;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            StStop: begin
                if (cnt_q == CntBit) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        frame_err_d = 1'b1;
                        state_d     = StWaitIdle;
                    end else if (parity_fail) begin
                        parity_err_d = 1'b1;
                        state_d      = StIdle;
                    end else begin
                        byte_d  = shift_q;
                        state_d = StDone;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            StWaitIdle: begin
                if (rx_s) state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Byte is loaded on entry to DONE so it is valid alongside the strobe.
    always_comb begin
        o_Byte       = byte_q;
        o_ready_read = (state_q == StDone);
        o_frame_err  = frame_err_q;
        o_parity_err = parity_err_q;
        o_busy       = (state_q != StIdle);
    end

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Self-checking bench for uart_byte_receiver: directed scenarios plus random
// frames, checked against an event model derived from the frame timing rules.
module tb_uart_byte_receiver;

    localparam int Cpb = 8;
`ifdef UART_RX_PARITY_EN
    localparam int FrameBits = 11;
    localparam bit ParEn     = 1'b1;
`else
    localparam int FrameBits = 10;
    localparam bit ParEn     = 1'b0;
`endif
    // Line fall to strobe: 2 sync cycles, mid-bit sample of the stop bit,
    // then one cycle to the registered event.
    localparam int EvLatency = 3 + Cpb / 2 + (FrameBits - 1) * Cpb;

    localparam int EvReady  = 0;
    localparam int EvFrame  = 1;
    localparam int EvParity = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         cyc;
    } ev_t;

    ev_t        exp_q[$];
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] byte_out;
    logic       ready, frame_err, parity_err, busy;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] last_good = 8'h00;

    uart_byte_receiver #(
        .CLKS_PER_BIT (Cpb)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_rx         (rx),
        .o_Byte       (byte_out),
        .o_ready_read (ready),
        .o_frame_err  (frame_err),
        .o_parity_err (parity_err),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Compare every observed event against the model queue.
    always @(negedge clk) begin : monitor
        ev_t        e;
        logic [2:0] seen;
        logic [2:0] want;
        if (rst_n) begin
            if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
                check_eq("missed_event_cycle", cyc, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            seen = {parity_err, frame_err, ready};
            if (seen != 3'b000) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_event", seen, 0);
                end else begin
                    e    = exp_q.pop_front();
                    want = 3'b001 << e.kind;
                    check_eq("event_kind", seen, want);
                    check_eq("event_cycle", cyc, e.cyc);
                    if (e.kind == EvReady) check_eq("strobe_byte", byte_out, e.data);
                end
            end
        end
    end

    // Called at a negedge; returns at a negedge with the line left at the stop value.
    task automatic send_frame(input logic [7:0] b, input bit stop, input bit par_ok);
        logic [10:0] bits;
        ev_t         e;
        bits      = '0;
        bits[8:1] = b;
        if (ParEn) begin
            bits[9]  = (^b) ^ !par_ok;
            bits[10] = stop;
        end else begin
            bits[9] = stop;
        end
        e.cyc  = cyc + EvLatency;
        e.data = b;
        if (!stop) begin
            e.kind = EvFrame;
        end else if (ParEn && !par_ok) begin
            e.kind = EvParity;
        end else begin
            e.kind    = EvReady;
            last_good = b;
        end
        exp_q.push_back(e);
        for (int j = 0; j < FrameBits; j++) begin
            rx = bits[j];
            for (int c = 0; c < Cpb; c++) begin
                if (j >= 1 && c == Cpb / 2) check_eq("busy_in_frame", busy, 1);
                @(negedge clk);
            end
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_byte", byte_out, 0);
        check_eq("rst_ready", ready, 0);
        check_eq("rst_frame_err", frame_err, 0);
        check_eq("rst_parity_err", parity_err, 0);
        check_eq("rst_busy", busy, 0);
    endtask

    initial begin
        logic [7:0] b;
        bit         stop;
        bit         par_ok;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        idle(10);

        send_frame(8'hA5, 1'b1, 1'b1);
        idle(2 * Cpb);
        check_eq("idle_busy_a5", busy, 0);
        check_eq("hold_byte_a5", byte_out, 8'hA5);

        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        idle(2 * Cpb);

        // Short low glitch must be rejected at the mid-start sample.
        rx = 1'b0;
        repeat (3) @(negedge clk);
        idle(2 * Cpb);
        check_eq("glitch_busy", busy, 0);

        // Bad stop bit followed by a long break.
        send_frame(8'h3C, 1'b0, 1'b1);
        rx = 1'b0;
        repeat (20 * Cpb) @(negedge clk);
        check_eq("break_busy", busy, 1);
        idle(2 * Cpb);
        check_eq("after_break_busy", busy, 0);
        check_eq("byte_kept_after_ferr", byte_out, 8'hFF);
        send_frame(8'h5A, 1'b1, 1'b1);
        idle(2 * Cpb);

        // Reset in the middle of data bit 4 of 0x3C.
        b  = 8'h3C;
        rx = 1'b0;
        repeat (Cpb) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            rx = b[k];
            repeat (Cpb) @(negedge clk);
        end
        rx = b[4];
        repeat (Cpb / 2) @(negedge clk);
        rst_n = 1'b0;
        rx    = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        last_good = 8'h00;
        idle(2 * Cpb);
        check_eq("post_reset_byte", byte_out, 0);
        send_frame(8'h81, 1'b1, 1'b1);
        idle(2 * Cpb);

        if (ParEn) begin
            send_frame(8'h07, 1'b1, 1'b1);
            idle(Cpb);
            send_frame(8'h07, 1'b1, 1'b0);
            idle(2 * Cpb);
            check_eq("byte_kept_after_perr", byte_out, 8'h07);
        end

        for (int n = 0; n < 30; n++) begin
            b      = 8'($urandom);
            stop   = ($urandom_range(0, 5) != 0);
            par_ok = ParEn ? ($urandom_range(0, 4) != 0) : 1'b1;
            send_frame(b, stop, par_ok);
            if (!stop) begin
                rx = 1'b0;
                repeat ($urandom_range(0, 3) * Cpb) @(negedge clk);
                idle(2 + $urandom_range(0, Cpb));
            end else begin
                idle($urandom_range(0, 3));
            end
        end

        idle(4 * Cpb);
        check_eq("pending_events", exp_q.size(), 0);
        check_eq("final_byte", byte_out, last_good);
        check_eq("final_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_byte_receiver.md
# uart_byte_receiver

Serial-to-byte front end for the ILA command path. It oversamples the asynchronous host UART line, deframes 8N1 (optionally 8E1) characters LSB-first and presents each valid byte with a one-cycle strobe. That strobe is the byte/ready pair consumed directly by the command-match stages (hold/trigger decoders). Malformed characters are reported on error pulses and are never strobed downstream.

## Interface
- CLKS_PER_BIT, 87, i_clk cycles per UART bit (10 MHz / 115200); minimum 4
- i_clk  in  1  system clock
- i_reset  in  1  synchronous, active-low reset
- i_rx  in  1  asynchronous UART line, idle high
- o_Byte  out  8  last valid received byte; stable until the next valid byte
- o_ready_read  out  1  one-cycle strobe, o_Byte valid in the same cycle
- o_frame_err  out  1  one-cycle pulse, stop bit sampled low
- o_parity_err  out  1  one-cycle pulse, parity mismatch (0 when parity compiled out)
- o_busy  out  1  high from start-bit detection until return to IDLE

## Operation
- i_rx passes through a two-flop synchronizer. All logic below uses the synchronized line rx_s.
- The bit counter is $clog2(CLKS_PER_BIT) bits wide and runs 0..CLKS_PER_BIT-1. The bit index is 3 bits, 0..7.
- IDLE: counter cleared. rx_s==0 → START.
- START: count to CLKS_PER_BIT/2-1 (integer division), then sample mid-bit.
  - Sample 0 → DATA, counter cleared.
  - Sample 1 (glitch) → IDLE, with no flag.
- DATA: every CLKS_PER_BIT cycles, sample into shift register bit[index], LSB first. After index 7 → PARITY if compiled in, else STOP.
- PARITY: sample after CLKS_PER_BIT cycles and compare against the XOR of the data bits (even parity).
- STOP: sample after CLKS_PER_BIT cycles.
  - Sample 1 with no parity error → DONE.
  - Sample 0 → frame error → WAIT_IDLE.
- DONE: load o_Byte, pulse o_ready_read → IDLE.
- WAIT_IDLE: remain until rx_s==1 → IDLE. This covers breaks and a line held low.
- If both frame and parity errors occur, only o_frame_err pulses. Neither strobes o_ready_read, and o_Byte is unchanged.
- Reset (any state, mid-frame included): state IDLE; o_Byte=8'h00; o_ready_read, o_frame_err, o_parity_err, o_busy = 0; synchronizer flops = 1.

## Timing
- Pin-to-detect latency: 2 cycles (synchronizer). IDLE→START occurs on the cycle rx_s is first seen low.
- Data bit k is sampled CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT cycles after start detection.
- o_ready_read asserts exactly 1 cycle after the stop-bit sample and is high for exactly 1 cycle.
- Error pulses assert in the cycle after the failing sample.
- Back-to-back frames are supported. A start edge arriving in the cycle after DONE is accepted because IDLE checks rx_s immediately. The stop-bit sample sits mid-bit, leaving CLKS_PER_BIT/2 cycles of margin.
- o_busy drops in the cycle the state enters IDLE.

## Configuration
- UART_RX_PARITY_EN defined: the PARITY state is present, the frame is 11 bits with an even parity bit, and a mismatch pulses o_parity_err and drops the byte.
- Not defined: there is no PARITY state, the frame is 10 bits, and o_parity_err is tied 0.

## Structure
- The shared package/header ila_uart_defs holds:
  - state encodings (IDLE, START, DATA, PARITY, STOP, DONE, WAIT_IDLE)
  - the default CLKS_PER_BIT value
  - the UART_RX_PARITY_EN guard documentation
- One sub-module: sync_2ff, a two-flop synchronizer with reset value 1. It is reused by other async ILA inputs.
- All remaining logic (FSM, bit counter, shift register, error flags) lives in uart_byte_receiver.

## Test plan
All scenarios use CLKS_PER_BIT=8.
- Send 0xA5 as 8N1 → exactly one o_ready_read pulse with o_Byte=8'hA5; o_busy high for the whole frame; no error pulses.
- Send 0x00 then 0xFF back-to-back with no idle gap → two strobes, 8'h00 then 8'hFF, each one cycle wide.
- Drive i_rx low for 3 cycles, then high → START rejects the glitch; no strobe, no error; back in IDLE.
- Send 0x3C with the stop bit low, then hold the line low 20 bit-times, then send 0x5A → one o_frame_err pulse, no strobe for 0x3C, o_Byte stays at its old value; after release, 8'h5A strobes.
- Assert i_reset mid-frame at data bit 4, release, then send 0x81 → all outputs 0 during reset; only 8'h81 is strobed afterwards.
- With UART_RX_PARITY_EN: send 0x07 with parity bit 1 → strobe of 8'h07. Send 0x07 with parity bit 0 → o_parity_err pulse and no strobe.
